// File: rtl/bfp_pkg.sv
// Shared types for the BFP compression datapath and its schedulers.
package bfp_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_SETUP = 2'd2,
    ARB_PASS  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [3:0] meth;
    logic [3:0] width;
  } comp_cfg_t;

endpackage

// File: rtl/bfp_rr_pick.sv
// Rotating-priority picker: the first asserted req at or after ptr (mod N_PORTS) wins.
module bfp_rr_pick #(
  parameter int N_PORTS = 4,
  parameter int ID_W    = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bfp_comp_arb.sv
// Packet-granular round-robin arbiter feeding a single bfp_comp; it owns the
// compressor config and only changes it once the compressor pipeline has drained.
module bfp_comp_arb
  import bfp_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int DRAIN_CYCLES = 16,
  parameter int ID_W         = $clog2(N_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PORTS*64-1:0] s_axis_tdata,
  input  logic [N_PORTS*8-1:0]  s_axis_tkeep,
  input  logic [N_PORTS-1:0]    s_axis_tvalid,
  output logic [N_PORTS-1:0]    s_axis_tready,
  input  logic [N_PORTS-1:0]    s_axis_tlast,
  input  logic [N_PORTS*32-1:0] s_axis_tuser,
  input  logic [N_PORTS*4-1:0]  cfg_comp_meth,
  input  logic [N_PORTS*4-1:0]  cfg_iq_width,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [31:0]           m_axis_tuser,
  output logic [ID_W-1:0]       m_axis_tid,
  output logic [3:0]            ctrl_ud_comp_meth,
  output logic [3:0]            ctrl_ud_iq_width,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt;
  comp_cfg_t        cfg_lat;
  comp_cfg_t        ctrl;
  logic [CNT_W-1:0] idle_cnt;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  comp_cfg_t        pick_cfg;
  logic             fire;
  logic             drained;

  bfp_rr_pick #(.N_PORTS(N_PORTS), .ID_W(ID_W)) u_pick (
    .req       (s_axis_tvalid),
    .ptr       (ptr),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  assign pick_cfg = {cfg_comp_meth[pick_id*4 +: 4], cfg_iq_width[pick_id*4 +: 4]};

  // Upstream handshake: a beat transfers on a rising edge where tvalid and tready
  // are both high; tready depends only on registered state, never on tvalid.
  // Downstream has no ready, so every registered m_axis_tvalid beat is consumed.
  assign fire    = (state == ARB_PASS) && s_axis_tvalid[gnt];
  assign drained = (idle_cnt == CNT_W'(DRAIN_CYCLES));
  assign busy    = (state != ARB_IDLE);

  assign ctrl_ud_comp_meth = ctrl.meth;
  assign ctrl_ud_iq_width  = ctrl.width;

  always_comb begin
    s_axis_tready = '0;
    if (state == ARB_PASS) s_axis_tready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      ptr           <= '0;
      gnt           <= '0;
      cfg_lat       <= '0;
      ctrl          <= '0;
      idle_cnt      <= CNT_W'(DRAIN_CYCLES);
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tid    <= '0;
    end else begin
      m_axis_tvalid <= fire;
      if (fire) begin
        m_axis_tdata <= s_axis_tdata[gnt*64 +: 64];
        m_axis_tkeep <= s_axis_tkeep[gnt*8 +: 8];
        m_axis_tlast <= s_axis_tlast[gnt];
        m_axis_tuser <= s_axis_tuser[gnt*32 +: 32];
        m_axis_tid   <= gnt;
      end

      // Counts output-idle cycles so a config swap waits out the compressor pipeline.
      if (fire)          idle_cnt <= '0;
      else if (!drained) idle_cnt <= idle_cnt + CNT_W'(1);

      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt     <= pick_id;
            cfg_lat <= pick_cfg;
            state   <= (pick_cfg == ctrl) ? ARB_PASS : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (drained) begin
            ctrl  <= cfg_lat;
            state <= ARB_SETUP;
          end
        end
        ARB_SETUP: state <= ARB_PASS;
        ARB_PASS: begin
          if (fire && s_axis_tlast[gnt]) begin
            state <= ARB_IDLE;
            ptr   <= (gnt == ID_W'(N_PORTS - 1)) ? '0 : gnt + ID_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfp_comp_arb.sv
// Directed bench for bfp_comp_arb: per-port packet drivers, beat scoreboard, grant log.
module tb_bfp_comp_arb;

  localparam int N  = 4;
  localparam int DR = 16;
  localparam int IW = 2;
  localparam int EW = IW + 1 + 32 + 8 + 64 + 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*64-1:0] s_axis_tdata;
  logic [N*8-1:0]  s_axis_tkeep;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N-1:0]    s_axis_tlast;
  logic [N*32-1:0] s_axis_tuser;
  logic [N*4-1:0]  cfg_comp_meth;
  logic [N*4-1:0]  cfg_iq_width;
  logic [63:0]     m_axis_tdata;
  logic [7:0]      m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [31:0]     m_axis_tuser;
  logic [IW-1:0]   m_axis_tid;
  logic [3:0]      ctrl_ud_comp_meth;
  logic [3:0]      ctrl_ud_iq_width;
  logic            busy;

  bfp_comp_arb #(.N_PORTS(N), .DRAIN_CYCLES(DR), .ID_W(IW)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .cfg_comp_meth     (cfg_comp_meth),
    .cfg_iq_width      (cfg_iq_width),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tid        (m_axis_tid),
    .ctrl_ud_comp_meth (ctrl_ud_comp_meth),
    .ctrl_ud_iq_width  (ctrl_ud_iq_width),
    .busy              (busy)
  );

  // scoreboard and stimulus state
  logic [EW-1:0] exp_q[$];
  int            g_port[$];
  int            g_first[$];
  int            g_last[$];
  int            rem[N], beat[N], len[N], more[N], gap_beat[N], gap_len[N];
  logic [63:0]   cur_data[N];
  logic [7:0]    cur_keep[N];
  logic [31:0]   cur_user[N];
  logic [7:0]    pkt_cfg[N];
  logic [7:0]    prev_ctrl;
  int            cyc, seq, n_asserts, n_fail, chg_cnt, chg_cyc, c0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic chk_order(input string tag, input int n, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    chk({tag, "_count"}, 128'(g_port.size()), 128'(n));
    for (int k = 0; k < n; k++) chk({tag, "_port"}, 128'(qget(g_port, k)), 128'(e[k]));
  endtask

  task automatic new_beat(input int p);
    cur_data[p] = {8'(p), 8'(seq), 16'(beat[p]), $urandom()};
    cur_keep[p] = 8'($urandom_range(1, 255));
    cur_user[p] = $urandom();
  endtask

  task automatic start_pkt(input int p, input int n, input logic [3:0] m, input logic [3:0] w);
    seq++;
    rem[p]  = n;
    len[p]  = n;
    beat[p] = 0;
    cfg_comp_meth[p*4 +: 4] = m;
    cfg_iq_width[p*4 +: 4]  = w;
    new_beat(p);
  endtask

  task automatic mark();
    prev_ctrl = {ctrl_ud_comp_meth, ctrl_ud_iq_width};
    chg_cnt = 0;
    chg_cyc = -1;
    g_port.delete();
    g_first.delete();
    g_last.delete();
  endtask

  // One clock: check outputs, drive inputs, predict accepted beats, advance to edge+1.
  task automatic cycle();
    logic [EW-1:0] e;
    logic          v;
    logic          gap;
    v = (exp_q.size() != 0);
    chk("m_valid", 128'(m_axis_tvalid), 128'(v));
    if (v) begin
      e = exp_q.pop_front();
      chk("m_beat", 128'({m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata,
                          ctrl_ud_comp_meth, ctrl_ud_iq_width}), 128'(e));
    end
    chk("ready_onehot", 128'($countones(s_axis_tready) <= 1), 128'(1));
    if ({ctrl_ud_comp_meth, ctrl_ud_iq_width} !== prev_ctrl) begin
      chg_cnt++;
      chg_cyc   = cyc;
      prev_ctrl = {ctrl_ud_comp_meth, ctrl_ud_iq_width};
    end
    for (int p = 0; p < N; p++) begin
      gap = (rem[p] > 0) && (beat[p] == gap_beat[p]) && (gap_len[p] > 0);
      s_axis_tvalid[p]         = (rem[p] > 0) && !gap;
      s_axis_tlast[p]          = (rem[p] == 1);
      s_axis_tdata[p*64 +: 64] = cur_data[p];
      s_axis_tkeep[p*8 +: 8]   = cur_keep[p];
      s_axis_tuser[p*32 +: 32] = cur_user[p];
      if (gap) gap_len[p]--;
      else if (!rst && s_axis_tvalid[p] && s_axis_tready[p]) begin
        if (beat[p] == 0) begin
          g_port.push_back(p);
          g_first.push_back(cyc);
          pkt_cfg[p] = {cfg_comp_meth[p*4 +: 4], cfg_iq_width[p*4 +: 4]};
        end
        if (rem[p] == 1) g_last.push_back(cyc);
        exp_q.push_back({IW'(p), s_axis_tlast[p], cur_user[p], cur_keep[p], cur_data[p], pkt_cfg[p]});
        rem[p]--;
        beat[p]++;
        if (rem[p] == 0 && more[p] > 0) begin
          more[p]--;
          rem[p]  = len[p];
          beat[p] = 0;
          seq++;
        end
        new_beat(p);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic pending();
    logic any;
    any = (exp_q.size() != 0);
    for (int p = 0; p < N; p++) if (rem[p] > 0 || more[p] > 0) any = 1'b1;
    return any;
  endfunction

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_budget"}, 128'(n < budget), 128'(1));
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    cycle();
    for (int p = 0; p < N; p++) begin
      rem[p] = 0; more[p] = 0; gap_len[p] = 0; gap_beat[p] = -1;
    end
    chk("rst_outputs", 128'({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tdata,
                             m_axis_tkeep, m_axis_tuser, ctrl_ud_comp_meth, ctrl_ud_iq_width, busy}),
        128'(0));
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_asserts = 0; n_fail = 0; cyc = 0; seq = 0; prev_ctrl = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    s_axis_tuser = '0; cfg_comp_meth = '0; cfg_iq_width = '0;
    for (int p = 0; p < N; p++) begin
      rem[p] = 0; beat[p] = 0; len[p] = 0; more[p] = 0; gap_beat[p] = -1; gap_len[p] = 0;
      cur_data[p] = '0; cur_keep[p] = '0; cur_user[p] = '0; pkt_cfg[p] = '0;
    end
    @(posedge clk);
    #1;
    apply_rst();

    // port 2, 4 beats, cfg {1,9} from reset ctrl 0: one WAIT (already drained), SETUP, PASS
    mark(); c0 = cyc;
    start_pkt(2, 4, 4'd1, 4'd9);
    run_idle("t1", 200);
    chk_order("t1", 1, 2, 0, 0, 0, 0);
    chk("t1_latency", 128'(qget(g_first, 0) - c0), 128'(3));
    chk("t1_len", 128'(qget(g_last, 0) - qget(g_first, 0)), 128'(3));
    chk("t1_busy", 128'(busy), 128'(0));

    // all ports valid, same cfg, 3-beat packets: RR order and single bubble
    apply_rst();
    mark();
    for (int p = 0; p < N; p++) start_pkt(p, 3, 4'd1, 4'd9);
    more[0] = 1;
    run_idle("t2", 300);
    chk_order("t2", 5, 0, 1, 2, 3, 0);
    for (int k = 1; k < 5; k++)
      chk("t2_bubble", 128'(qget(g_first, k) - qget(g_last, k - 1)), 128'(2));
    chk("t2_ctrl_changes", 128'(chg_cnt), 128'(1));

    // port 0 {1,9} then port 1 {1,14}: ctrl waits out the drain, then SETUP, then PASS
    mark();
    start_pkt(0, 2, 4'd1, 4'd9);
    for (int i = 0; i < 50 && g_port.size() < 1; i++) cycle();
    chk("t3_start", 128'(g_port.size() >= 1), 128'(1));
    start_pkt(1, 2, 4'd1, 4'd14);
    run_idle("t3", 200);
    chk_order("t3", 2, 0, 1, 0, 0, 0);
    chk("t3_ctrl_changes", 128'(chg_cnt), 128'(1));
    chk("t3_drain", 128'(chg_cyc - qget(g_last, 0)), 128'(DR + 2));
    chk("t3_setup_gap", 128'(qget(g_first, 1) - chg_cyc), 128'(1));

    // port 1 drops tvalid for 5 cycles mid-packet while port 2 waits
    mark();
    gap_beat[1] = 2; gap_len[1] = 5;
    start_pkt(1, 6, 4'd1, 4'd14);
    for (int i = 0; i < 50 && g_port.size() < 1; i++) cycle();
    chk("t4_start", 128'(g_port.size() >= 1), 128'(1));
    start_pkt(2, 1, 4'd1, 4'd14);
    run_idle("t4", 200);
    gap_beat[1] = -1;
    chk_order("t4", 2, 1, 2, 0, 0, 0);
    chk("t4_span", 128'(qget(g_last, 0) - qget(g_first, 0)), 128'(10));
    chk("t4_next", 128'(qget(g_first, 1) - qget(g_last, 0)), 128'(2));
    chk("t4_ctrl_changes", 128'(chg_cnt), 128'(0));

    // cfg change on port 3 mid-packet only takes effect at its next grant
    mark();
    start_pkt(3, 4, 4'd1, 4'd14);
    for (int i = 0; i < 50 && beat[3] < 2; i++) cycle();
    chk("t5_mid", 128'(beat[3] >= 2), 128'(1));
    cfg_iq_width[12 +: 4] = 4'd9;
    run_idle("t5a", 200);
    start_pkt(3, 2, 4'd1, 4'd9);
    run_idle("t5b", 200);
    chk_order("t5", 2, 3, 3, 0, 0, 0);
    chk("t5_ctrl_changes", 128'(chg_cnt), 128'(1));
    chk("t5_drain", 128'(qget(g_first, 1) - qget(g_last, 0)), 128'(DR + 3));

    // single-beat packet, same cfg: granted next cycle, straight back to IDLE
    mark(); c0 = cyc;
    start_pkt(1, 1, 4'd1, 4'd9);
    run_idle("t6a", 100);
    chk("t6_single_lat", 128'(qget(g_first, 0) - c0), 128'(1));
    chk("t6_single_len", 128'(qget(g_last, 0) - qget(g_first, 0)), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));

    // reset during beat 2 of a 6-beat packet; pointer must restart at port 0
    start_pkt(2, 6, 4'd1, 4'd9);
    for (int i = 0; i < 50 && beat[2] < 2; i++) cycle();
    chk("t6_mid", 128'(beat[2] >= 2), 128'(1));
    apply_rst();
    mark();
    start_pkt(1, 2, 4'd1, 4'd9);
    start_pkt(3, 2, 4'd1, 4'd9);
    run_idle("t6b", 200);
    chk_order("t6", 2, 1, 3, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
